// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Packet-level round-robin arbiter that shares one UART TX stream.
//            A grant lasts until the packet ends or MAX_BURST beats have passed.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*DATA_BITS-1:0]   s_tdata,
    input  logic [NUM_REQ-1:0]             s_tvalid,
    input  logic [NUM_REQ-1:0]             s_tlast,
    output logic [NUM_REQ-1:0]             s_tready,
    output logic [DATA_BITS-1:0]           m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           pkt_done
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [c_CNT_W-1:0] c_BURST_LAST = c_CNT_W'(MAX_BURST - 1);
    localparam logic [c_IDX_W:0]   c_NUM        = (c_IDX_W + 1)'(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST_INIT  = c_IDX_W'(NUM_REQ - 1);

    localparam logic [0:0] c_ST_ARB   = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    logic [0:0]           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_CNT_W-1:0]   r_beat_cnt;

    logic [DATA_BITS-1:0] w_lane [NUM_REQ];
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_pick;
    logic [c_IDX_W:0]     w_cand;
    logic                 w_active;
    logic                 w_beat;
    logic                 w_exit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign w_lane[gi] = s_tdata[gi*DATA_BITS +: DATA_BITS];
    end

    // Rotating search starting just after the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last_grant} + (c_IDX_W + 1)'(k);
            if (w_cand >= c_NUM) begin
                w_cand = w_cand - c_NUM;
            end
            if (!w_found && s_tvalid[w_cand[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[c_IDX_W-1:0];
            end
        end
    end

    // r_last_grant doubles as the index of the owner while in GRANT.
    // Gating with rst keeps a beat from being accepted in the reset cycle.
    assign w_active = (r_state == c_ST_GRANT) && !rst;
    assign m_tvalid = w_active && s_tvalid[r_last_grant];
    assign m_tdata  = w_active ? w_lane[r_last_grant] : '0;
    assign s_tready = w_active ? (r_grant & {NUM_REQ{m_tready}}) : '0;
    assign w_beat   = m_tvalid && m_tready;
    assign w_exit   = w_beat && (s_tlast[r_last_grant] || (r_beat_cnt == c_BURST_LAST));
    assign pkt_done = w_exit;
    assign busy     = (r_state == c_ST_GRANT);
    assign grant    = r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_ARB;
            r_grant      <= '0;
            r_last_grant <= c_LAST_INIT;
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_ARB: begin
                    if (w_found) begin
                        r_state      <= c_ST_GRANT;
                        r_grant      <= NUM_REQ'(1) << w_pick;
                        r_last_grant <= w_pick;
                        r_beat_cnt   <= '0;
                    end
                end
                default: begin
                    if (w_exit) begin
                        r_state    <= c_ST_ARB;
                        r_grant    <= '0;
                        r_beat_cnt <= '0;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Randomized bench for uart_tx_arbiter against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int c_N  = 4;
    localparam int c_DB = 8;
    localparam int c_MB = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_N*c_DB-1:0] s_tdata;
    logic [c_N-1:0]    s_tvalid;
    logic [c_N-1:0]    s_tlast;
    logic [c_N-1:0]    s_tready;
    logic [c_DB-1:0]   m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [c_N-1:0]    grant;
    logic              busy;
    logic              pkt_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester beat queues {last, data}, and the expected output stream.
    logic [8:0] q [c_N][$];
    int         exp_req  [$];
    logic [7:0] exp_data [$];
    bit         exp_end  [$];

    uart_tx_arbiter #(
        .NUM_REQ   (c_N),
        .DATA_BITS (c_DB),
        .MAX_BURST (c_MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .grant    (grant),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            q[r].push_back({(b == len - 1), 8'($urandom)});
        end
    endtask

    // Round-robin over requesters with data; a grant takes beats until tlast or MAX_BURST.
    task automatic build_model();
        logic [8:0] mq [c_N][$];
        logic [8:0] b;
        int last = c_N - 1;
        int r;
        int n;
        bit done;
        bit any;
        for (int i = 0; i < c_N; i++) mq[i] = q[i];
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            r = 0;
            for (int k = 1; k <= c_N; k++) begin
                if (!any && mq[(last + k) % c_N].size() > 0) begin
                    any = 1'b1;
                    r = (last + k) % c_N;
                end
            end
            if (any) begin
                last = r;
                n = 0;
                done = 1'b0;
                while (!done) begin
                    b = mq[r].pop_front();
                    n++;
                    done = b[8] || (n == c_MB);
                    exp_req.push_back(r);
                    exp_data.push_back(b[7:0]);
                    exp_end.push_back(done);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_tvalid = '0;
        m_tready = 1'b1;
        @(negedge clk);
        #3;
        check_eq("rst_tready", s_tready, 0);
        check_eq("rst_mvalid", m_tvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mvalid2", m_tvalid, 0);
        check_eq("rst_mdata", m_tdata, 0);
        check_eq("rst_done", pkt_done, 0);
    endtask

    task automatic run_traffic(input bit gaps, input bit rdy_rand);
        int idle_run = 0;
        bit prev_busy = 1'b0;
        int cyc = 0;
        int g;
        logic [8:0] hd;
        logic [3:0] eg;
        build_model();
        while (exp_req.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            for (int i = 0; i < c_N; i++) begin
                if (q[i].size() > 0) begin
                    hd = q[i][0];
                    s_tdata[i*c_DB +: c_DB] = hd[7:0];
                    s_tlast[i]  = hd[8];
                    s_tvalid[i] = (grant[i] && gaps) ? ($urandom_range(3) != 0) : 1'b1;
                end else begin
                    s_tdata[i*c_DB +: c_DB] = 8'($urandom);
                    s_tlast[i]  = 1'($urandom);
                    s_tvalid[i] = 1'b0;
                end
            end
            m_tready = rdy_rand ? 1'($urandom) : 1'b1;
            #3;
            g  = exp_req[0];
            eg = busy ? (4'b0001 << g) : 4'b0000;
            check_eq("grant", grant, eg);
            check_eq("s_tready", s_tready, eg & {4{m_tready}});
            check_eq("m_tvalid", m_tvalid, busy && s_tvalid[g]);
            if (!busy) check_eq("idle_mdata", m_tdata, 0);
            if (busy && !prev_busy) begin
                check_eq("bubble", idle_run, 1);
                idle_run = 0;
            end else if (!busy) begin
                idle_run++;
            end
            prev_busy = busy;
            if (m_tvalid && m_tready) begin
                check_eq("m_tdata", m_tdata, exp_data[0]);
                check_eq("pkt_done", pkt_done, exp_end[0]);
                void'(q[g].pop_front());
                void'(exp_req.pop_front());
                void'(exp_data.pop_front());
                void'(exp_end.pop_front());
            end else begin
                check_eq("pkt_done_idle", pkt_done, 0);
            end
            cyc++;
        end
        if (exp_req.size() > 0) check_eq("timeout", exp_req.size(), 0);
        exp_req.delete();
        exp_data.delete();
        exp_end.delete();
        for (int i = 0; i < c_N; i++) q[i].delete();
        @(negedge clk);
        s_tvalid = '0;
        m_tready = 1'b1;
        #3;
        check_eq("drain_busy", busy, 0);
        check_eq("drain_grant", grant, 0);
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        do_reset();

        // Idle: nothing requested.
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #3;
            check_eq("idle_grant", grant, 0);
            check_eq("idle_mvalid", m_tvalid, 0);
            check_eq("idle_busy", busy, 0);
        end

        // Req1 three-beat packet.
        q[1].push_back(9'h0A1);
        q[1].push_back(9'h0A2);
        q[1].push_back(9'h1A3);
        run_traffic(1'b0, 1'b0);

        // Every requester with a 2-beat packet.
        do_reset();
        for (int i = 0; i < c_N; i++) add_pkt(i, 2);
        run_traffic(1'b0, 1'b0);

        // Long packet cut at MAX_BURST with a competing single beat.
        do_reset();
        add_pkt(0, 20);
        add_pkt(2, 1);
        run_traffic(1'b0, 1'b0);

        // Backpressure on a 10-beat packet.
        do_reset();
        add_pkt($urandom_range(c_N - 1), 10);
        run_traffic(1'b0, 1'b1);

        // Reset in the middle of a req3 packet.
        do_reset();
        @(negedge clk);
        s_tvalid = 4'b1000;
        s_tlast  = '0;
        s_tdata  = 32'($urandom);
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #3;
        check_eq("mid_grant", grant, 4'b1000);
        @(negedge clk);
        rst = 1'b1;
        #3;
        check_eq("rstcyc_tready", s_tready, 0);
        check_eq("rstcyc_mvalid", m_tvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = '0;
        #3;
        check_eq("post_grant", grant, 0);
        check_eq("post_mvalid", m_tvalid, 0);
        check_eq("post_tready", s_tready, 0);
        check_eq("post_busy", busy, 0);
        add_pkt(0, 3);
        add_pkt(3, 3);
        run_traffic(1'b0, 1'b1);

        // Random mixes with valid gaps and backpressure.
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int i = 0; i < c_N; i++) begin
                if ($urandom_range(1) == 1 || i == round % c_N) begin
                    for (int p = 0; p < int'($urandom_range(3, 1)); p++) begin
                        add_pkt(i, $urandom_range(20, 1));
                    end
                end
            end
            run_traffic(1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
